adiabatic_mux_sched: RTL and testbench

ADIABATIC_MUX_SCHED -- requirements
Module: adiabatic_mux_sched

---
 rtl/adiabatic_mux_sched.sv | 142 ++++++++++++++
 tb/tb_adiabatic_mux_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/adiabatic_mux_sched.sv
// rtl/adiabatic_mux_sched.sv - round-robin scheduler sequencing a shared mux through adiabatic power-clock phases
module adiabatic_mux_sched #(
  parameter int PHASE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic ramp_up,
  output logic hold,
  output logic ramp_dn,
  output logic done_a,
  output logic done_b,
  output logic busy
);

  localparam int CW = $clog2(PHASE_CYC) + 1;
  localparam logic [CW-1:0] PH  = CW'(PHASE_CYC);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RAMPUP = 3'd2,
    HOLD   = 3'd3,
    RAMPDN = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          sel_q, sel_d;
  logic          last_b_q, last_b_d;   // 1 = B was granted last, so A wins the next contention
  logic          ramp_up_q, hold_q, ramp_dn_q;
  logic          done_a_q, done_b_q, busy_q;
  logic          pick_a;

  // Next-state, arbitration and phase counter; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_a_d  = gnt_a_q;
    gnt_b_d  = gnt_b_q;
    sel_d    = sel_q;
    last_b_d = last_b_q;
    pick_a   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          pick_a   = req_a && (!req_b || last_b_q);
          state_d  = SETTLE;
          gnt_a_d  = pick_a;
          gnt_b_d  = !pick_a;
          sel_d    = pick_a;
          last_b_d = !pick_a;
        end
      end
      SETTLE: begin
        state_d = RAMPUP;
        cnt_d   = PH;
      end
      RAMPUP: begin
        if (cnt_q == ONE) begin
          state_d = HOLD;
          cnt_d   = PH;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLD: begin
        if (cnt_q == ONE) begin
          state_d = RAMPDN;
          cnt_d   = PH;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      RAMPDN: begin
        if (cnt_q == ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
      end
    endcase
  end

  // State, counter, grant and registered phase outputs; reset wins over everything, even mid-transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      sel_q     <= 1'b0;
      last_b_q  <= 1'b1;
      ramp_up_q <= 1'b0;
      hold_q    <= 1'b0;
      ramp_dn_q <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      sel_q     <= sel_d;
      last_b_q  <= last_b_d;
      ramp_up_q <= (state_d == RAMPUP);
      hold_q    <= (state_d == HOLD);
      ramp_dn_q <= (state_d == RAMPDN);
      done_a_q  <= (state_d == RAMPDN) && (cnt_d == ONE) && gnt_a_d;
      done_b_q  <= (state_d == RAMPDN) && (cnt_d == ONE) && gnt_b_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign sel     = sel_q;
  assign ramp_up = ramp_up_q;
  assign hold    = hold_q;
  assign ramp_dn = ramp_dn_q;
  assign done_a  = done_a_q;
  assign done_b  = done_b_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adiabatic_mux_sched.sv
// tb/tb_adiabatic_mux_sched.sv - scoreboard bench for adiabatic_mux_sched at PHASE_CYC 4 and 1
module tb_adiabatic_mux_sched;

  logic clk = 1'b0;
  logic rst, req_a, req_b;
  logic [1:0] gnt_a, gnt_b, sel, ramp_up, hold, ramp_dn, done_a, done_b, busy;

  always #5 clk = ~clk;

  adiabatic_mux_sched #(.PHASE_CYC(4)) u_p4 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a[0]), .gnt_b(gnt_b[0]), .sel(sel[0]),
    .ramp_up(ramp_up[0]), .hold(hold[0]), .ramp_dn(ramp_dn[0]),
    .done_a(done_a[0]), .done_b(done_b[0]), .busy(busy[0])
  );

  adiabatic_mux_sched #(.PHASE_CYC(1)) u_p1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a[1]), .gnt_b(gnt_b[1]), .sel(sel[1]),
    .ramp_up(ramp_up[1]), .hold(hold[1]), .ramp_dn(ramp_dn[1]),
    .done_a(done_a[1]), .done_b(done_b[1]), .busy(busy[1])
  );

  // Reference model: a transaction is just an offset k counted from the grant edge
  typedef struct {
    bit busy;
    bit cur_a;
    bit last_b;
    bit sel;
    int k;
  } mdl_t;

  mdl_t       m [2];
  int         pc [2] = '{4, 1};
  logic [8:0] exp_q [2][$];
  bit         txn_q [2][$];
  int         tests = 0;
  int         fails = 0;

  function automatic logic [8:0] pred(int i);
    int  p = pc[i];
    int  k = m[i].k;
    bit  b = m[i].busy;
    bit  ru = b && k >= 1 && k <= p;
    bit  ho = b && k > p && k <= 2 * p;
    bit  rd = b && k > 2 * p && k <= 3 * p;
    bit  dn = b && k == 3 * p;
    return {b, b && m[i].cur_a, b && !m[i].cur_a, m[i].sel, ru, ho, rd,
            dn && m[i].cur_a, dn && !m[i].cur_a};
  endfunction

  task automatic model_step(input bit r, input bit a, input bit b);
    bit pa;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m[i].busy = 0; m[i].k = 0; m[i].sel = 0; m[i].cur_a = 0; m[i].last_b = 1;
        txn_q[i].delete();
      end else if (!m[i].busy) begin
        if (a || b) begin
          pa = a && (!b || m[i].last_b);
          m[i].busy = 1; m[i].k = 0; m[i].cur_a = pa; m[i].sel = pa; m[i].last_b = !pa;
          txn_q[i].push_back(pa);
        end
      end else if (m[i].k == 3 * pc[i]) begin
        m[i].busy = 0;
      end else begin
        m[i].k++;
      end
      exp_q[i].push_back(pred(i));
    end
  endtask

  task automatic cyc(input bit r, input bit a, input bit b);
    rst = r; req_a = a; req_b = b;
    @(posedge clk);
    model_step(r, a, b);
    #1;
  endtask

  // Monitor: compare every registered output vector and every done pulse against the scoreboard
  always @(negedge clk) begin
    logic [8:0] e, got;
    bit         ea;
    for (int i = 0; i < 2; i++) begin
      if (exp_q[i].size() > 0) begin
        e   = exp_q[i].pop_front();
        got = {busy[i], gnt_a[i], gnt_b[i], sel[i], ramp_up[i], hold[i], ramp_dn[i], done_a[i], done_b[i]};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs dut%0d t=%0t got=%b want=%b (busy,ga,gb,sel,ru,ho,rd,da,db)", i, $time, got, e);
        end
      end
      if (done_a[i] === 1'b1 || done_b[i] === 1'b1) begin
        tests++;
        if (txn_q[i].size() == 0) begin
          fails++;
          $display("FAIL done_owner dut%0d t=%0t got done with no pending transaction", i, $time);
        end else begin
          ea = txn_q[i].pop_front();
          if (done_a[i] !== ea || done_b[i] !== !ea) begin
            fails++;
            $display("FAIL done_owner dut%0d t=%0t got da=%b db=%b want da=%b", i, $time, done_a[i], done_b[i], ea);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m[i].busy = 0; m[i].k = 0; m[i].sel = 0; m[i].cur_a = 0; m[i].last_b = 1;
    end
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) cyc(1, 0, 0);
    // single A transaction
    cyc(0, 1, 0);
    repeat (15) cyc(0, 0, 0);
    // both held: alternating grants
    repeat (60) cyc(0, 1, 1);
    repeat (14) cyc(0, 0, 0);
    // one-cycle B pulse
    cyc(0, 0, 1);
    repeat (14) cyc(0, 0, 0);
    // reset in HOLD, then contention must grant A
    cyc(0, 1, 0);
    repeat (6) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    repeat (14) cyc(0, 0, 0);
    // A arrives during B's HOLD and waits for IDLE
    cyc(0, 0, 1);
    repeat (6) cyc(0, 0, 0);
    repeat (10) cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 0);
    // randomized traffic with occasional reset
    repeat (1500) cyc($urandom_range(0, 99) < 2, 1'($urandom % 2), 1'($urandom % 2));
    cyc(0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
